// File: rtl/syn_avm_lb_master_pkg.sv
// syn_avm_lb_master_pkg: shared LB bridge defaults, timeout read pattern and FSM state encoding.
package syn_avm_lb_master_pkg;

    localparam int          LB_ADDR_W  = 16;
    localparam int          LB_DATA_W  = 32;
    localparam logic [31:0] TO_RD_DATA = 32'hDEADBEEF;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ISSUE   = 3'd1,
        ST_WAIT_RD = 3'd2,
        ST_WAIT_WR = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

endpackage

// File: rtl/syn_avm_lb_master_to_cntr.sv
// syn_avm_lb_master_to_cntr: response timeout counter with clear, enable and expire on the last counted cycle.
module syn_avm_lb_master_to_cntr #(
    parameter int P_W     = 8,
    parameter int P_LIMIT = 200
) (
    input  logic clk_ir,
    input  logic rst_il,
    input  logic clr_ih,
    input  logic en_ih,
    output logic exp_oh
);

    localparam logic [P_W-1:0] LAST = P_W'(P_LIMIT - 1);

    logic [P_W-1:0] cnt_q, cnt_d;

    always_comb cnt_d = clr_ih ? '0 : en_ih ? cnt_q + 1'b1 : cnt_q;

    assign exp_oh = en_ih && (cnt_q == LAST);

    always_ff @(posedge clk_ir or negedge rst_il) begin
        if (!rst_il) cnt_q <= '0;
        else         cnt_q <= cnt_d;
    end

endmodule

// File: rtl/syn_avm_lb_master.sv
// syn_avm_lb_master: Avalon-MM slave to Local Bus initiator; one LB strobe per transfer,
// waitrequest held until the LB response or a timeout.
module syn_avm_lb_master
    import syn_avm_lb_master_pkg::*;
#(
    parameter int                     P_LB_ADDR_W  = LB_ADDR_W,
    parameter int                     P_LB_DATA_W  = LB_DATA_W,
    parameter int                     P_TO_CNT_W   = 8,
    parameter int                     P_TO_CYCLES  = 200,
    parameter logic [P_LB_DATA_W-1:0] P_TO_RD_DATA = TO_RD_DATA
) (
    input  logic                   clk_ir,
    input  logic                   rst_il,
    input  logic [P_LB_ADDR_W-1:0] avs_address_id,
    input  logic                   avs_read_ih,
    input  logic                   avs_write_ih,
    input  logic [P_LB_DATA_W-1:0] avs_writedata_id,
    output logic [P_LB_DATA_W-1:0] avs_readdata_od,
    output logic                   avs_waitrequest_oh,
    output logic                   lb_rd_en_oh,
    output logic                   lb_wr_en_oh,
    output logic [P_LB_ADDR_W-1:0] lb_addr_od,
    output logic [P_LB_DATA_W-1:0] lb_wr_data_od,
    input  logic                   lb_rd_valid_ih,
    input  logic [P_LB_DATA_W-1:0] lb_rd_data_id,
    input  logic                   lb_wr_valid_ih,
    input  logic                   to_clr_ih,
    output logic                   to_err_oh,
    output logic [P_LB_ADDR_W-1:0] to_addr_od
);

    state_t state_q;
    logic   rd_pend_q;
    logic   to_exp, to_hit;

    syn_avm_lb_master_to_cntr #(
        .P_W     (P_TO_CNT_W),
        .P_LIMIT (P_TO_CYCLES)
    ) u_to_cntr (
        .clk_ir (clk_ir),
        .rst_il (rst_il),
        .clr_ih (state_q == ST_ISSUE),
        .en_ih  (state_q == ST_WAIT_RD || state_q == ST_WAIT_WR),
        .exp_oh (to_exp)
    );

    assign avs_waitrequest_oh = (state_q != ST_DONE);
    // A response landing on the expiry cycle still counts as a real completion.
    assign to_hit = to_exp && !(state_q == ST_WAIT_RD ? lb_rd_valid_ih : lb_wr_valid_ih);

    always_ff @(posedge clk_ir or negedge rst_il) begin
        if (!rst_il) begin
            state_q         <= ST_IDLE;
            rd_pend_q       <= 1'b0;
            lb_rd_en_oh     <= 1'b0;
            lb_wr_en_oh     <= 1'b0;
            lb_addr_od      <= '0;
            lb_wr_data_od   <= '0;
            avs_readdata_od <= '0;
            to_err_oh       <= 1'b0;
            to_addr_od      <= '0;
        end else begin
            lb_rd_en_oh <= 1'b0;
            lb_wr_en_oh <= 1'b0;
            if (to_clr_ih) begin
                to_err_oh  <= 1'b0;
                to_addr_od <= '0;
            end
            // Set beats clear; only the first timeout since the last clear is recorded.
            if (to_hit) begin
                to_err_oh <= 1'b1;
                if (!to_err_oh || to_clr_ih) to_addr_od <= lb_addr_od;
            end
            case (state_q)
                ST_IDLE: begin
                    if (avs_write_ih) begin
                        state_q       <= ST_ISSUE;
                        lb_wr_en_oh   <= 1'b1;
                        lb_addr_od    <= avs_address_id;
                        lb_wr_data_od <= avs_writedata_id;
                        rd_pend_q     <= avs_read_ih;
                    end else if (avs_read_ih || rd_pend_q) begin
                        state_q     <= ST_ISSUE;
                        lb_rd_en_oh <= 1'b1;
                        rd_pend_q   <= 1'b0;
                        if (!rd_pend_q) lb_addr_od <= avs_address_id;
                    end
                end
                ST_ISSUE: state_q <= lb_wr_en_oh ? ST_WAIT_WR : ST_WAIT_RD;
                ST_WAIT_RD: begin
                    if (lb_rd_valid_ih || to_hit) begin
                        state_q         <= ST_DONE;
                        avs_readdata_od <= lb_rd_valid_ih ? lb_rd_data_id : P_TO_RD_DATA;
                    end
                end
                ST_WAIT_WR: if (lb_wr_valid_ih || to_hit) state_q <= ST_DONE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule
